// File: rtl/ofs_asp_hostmem_rd_page_splitter.sv
// Read-request page splitter for one PIM host-memory channel: bursts that would
// cross a physical page are reissued as page-bounded sub-bursts, in address order.
module ofs_asp_hostmem_rd_page_splitter #(
    parameter int ADDR_WIDTH      = 42,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 6,
    parameter int PAGE_LINES_LOG2 = 6
) (
    input  logic                       afu_clk,
    input  logic                       afu_reset_n,

    input  logic                       s_read,
    input  logic [ADDR_WIDTH-1:0]      s_address,
    input  logic [BURST_CNT_WIDTH-1:0] s_burstcount,
    output logic                       s_waitrequest,
    output logic [DATA_WIDTH-1:0]      s_readdata,
    output logic                       s_readdatavalid,

    output logic                       m_read,
    output logic [ADDR_WIDTH-1:0]      m_address,
    output logic [BURST_CNT_WIDTH-1:0] m_burstcount,
    input  logic                       m_waitrequest,
    input  logic [DATA_WIDTH-1:0]      m_readdata,
    input  logic                       m_readdatavalid,

    output logic                       err_bad_burst,
    output logic [31:0]                split_count
);

    // Wide enough to hold both a full page of lines and any burstcount without overflow.
    localparam int CW = ((BURST_CNT_WIDTH > PAGE_LINES_LOG2 + 1) ? BURST_CNT_WIDTH : PAGE_LINES_LOG2 + 1) + 1;
    localparam logic [CW-1:0] PAGE_LINES = {{(CW-1){1'b0}}, 1'b1} << PAGE_LINES_LOG2;
    localparam logic [CW-1:0] MAX_BURST  = {{(CW-1){1'b0}}, 1'b1} << (BURST_CNT_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    state_t                     state_q,      state_d;
    logic                       mRead_q,      mRead_d;
    logic [ADDR_WIDTH-1:0]      mAddr_q,      mAddr_d;
    logic [BURST_CNT_WIDTH-1:0] mBurst_q,     mBurst_d;
    logic [ADDR_WIDTH-1:0]      nextAddr_q,   nextAddr_d;
    logic [BURST_CNT_WIDTH-1:0] remain_q,     remain_d;
    logic                       err_q,        err_d;
    logic [31:0]                splitCount_q, splitCount_d;

    logic                       outFree;
    logic                       accept;
    logic                       badBurst;
    logic [CW-1:0]              burstWide;
    logic [CW-1:0]              room;
    logic [CW-1:0]              remainWide;
    logic [CW-1:0]              subLen;
    logic [BURST_CNT_WIDTH-1:0] afterRemain;

    assign outFree    = !mRead_q || !m_waitrequest;
    assign accept     = s_read && !s_waitrequest;
    assign burstWide  = {{(CW-BURST_CNT_WIDTH){1'b0}}, s_burstcount};
    assign room       = PAGE_LINES - {{(CW-PAGE_LINES_LOG2){1'b0}}, s_address[PAGE_LINES_LOG2-1:0]};
    assign badBurst   = (burstWide == '0) || (burstWide > MAX_BURST);
    assign remainWide = {{(CW-BURST_CNT_WIDTH){1'b0}}, remain_q};
    assign subLen     = (remainWide > PAGE_LINES) ? PAGE_LINES : remainWide;
    assign afterRemain = remain_q - subLen[BURST_CNT_WIDTH-1:0];

    always_ff @(posedge afu_clk or negedge afu_reset_n) begin
        if (!afu_reset_n) begin
            state_q      <= IDLE;
            mRead_q      <= 1'b0;
            mAddr_q      <= '0;
            mBurst_q     <= '0;
            nextAddr_q   <= '0;
            remain_q     <= '0;
            err_q        <= 1'b0;
            splitCount_q <= '0;
        end else begin
            state_q      <= state_d;
            mRead_q      <= mRead_d;
            mAddr_q      <= mAddr_d;
            mBurst_q     <= mBurst_d;
            nextAddr_q   <= nextAddr_d;
            remain_q     <= remain_d;
            err_q        <= err_d;
            splitCount_q <= splitCount_d;
        end
    end

    // A truncated first-sub-burst length never exceeds the burstcount, so the narrowing is safe.
    always_comb begin
        state_d      = state_q;
        mRead_d      = mRead_q;
        mAddr_d      = mAddr_q;
        mBurst_d     = mBurst_q;
        nextAddr_d   = nextAddr_q;
        remain_d     = remain_q;
        err_d        = err_q;
        splitCount_d = splitCount_q;

        if (outFree) begin
            mRead_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (badBurst) begin
                        err_d = 1'b1;
                    end else if (burstWide <= room) begin
                        mRead_d  = 1'b1;
                        mAddr_d  = s_address;
                        mBurst_d = s_burstcount;
                    end else begin
                        mRead_d      = 1'b1;
                        mAddr_d      = s_address;
                        mBurst_d     = room[BURST_CNT_WIDTH-1:0];
                        nextAddr_d   = s_address + {{(ADDR_WIDTH-CW){1'b0}}, room};
                        remain_d     = s_burstcount - room[BURST_CNT_WIDTH-1:0];
                        splitCount_d = splitCount_q + 32'd1;
                        state_d      = SPLIT;
                    end
                end
            end
            SPLIT: begin
                if (outFree) begin
                    mRead_d    = 1'b1;
                    mAddr_d    = nextAddr_q;
                    mBurst_d   = subLen[BURST_CNT_WIDTH-1:0];
                    nextAddr_d = nextAddr_q + {{(ADDR_WIDTH-CW){1'b0}}, subLen};
                    remain_d   = afterRemain;
                    if (afterRemain == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        s_waitrequest   = !afu_reset_n || (state_q == SPLIT) || (mRead_q && m_waitrequest);
        s_readdata      = m_readdata;
        s_readdatavalid = m_readdatavalid;
        m_read          = mRead_q;
        m_address       = mAddr_q;
        m_burstcount    = mBurst_q;
        err_bad_burst   = err_q;
        split_count     = splitCount_q;
    end

endmodule

// File: tb/tb_ofs_asp_hostmem_rd_page_splitter.sv
// Directed bench for the host-memory read page splitter, ending with a randomized
// burst run checked against a request queue of expected line addresses.
module tb_ofs_asp_hostmem_rd_page_splitter;

   localparam int AW = 42;
   localparam int DW = 512;
   localparam int BW = 6;

   logic          afu_clk = 1'b0;
   logic          afu_reset_n;
   logic          s_read;
   logic [AW-1:0] s_address;
   logic [BW-1:0] s_burstcount;
   logic          s_waitrequest;
   logic [DW-1:0] s_readdata;
   logic          s_readdatavalid;
   logic          m_read;
   logic [AW-1:0] m_address;
   logic [BW-1:0] m_burstcount;
   logic          m_waitrequest;
   logic [DW-1:0] m_readdata;
   logic          m_readdatavalid;
   logic          err_bad_burst;
   logic [31:0]   split_count;

   int            testCount = 0;
   int            failCount = 0;
   bit            monEn = 1'b0;
   logic [AW-1:0] qAddr[$];
   int            qRem[$];
   longint        acceptedLines = 0;
   longint        issuedLines = 0;

   ofs_asp_hostmem_rd_page_splitter dut (
      .afu_clk         (afu_clk),
      .afu_reset_n     (afu_reset_n),
      .s_read          (s_read),
      .s_address       (s_address),
      .s_burstcount    (s_burstcount),
      .s_waitrequest   (s_waitrequest),
      .s_readdata      (s_readdata),
      .s_readdatavalid (s_readdatavalid),
      .m_read          (m_read),
      .m_address       (m_address),
      .m_burstcount    (m_burstcount),
      .m_waitrequest   (m_waitrequest),
      .m_readdata      (m_readdata),
      .m_readdatavalid (m_readdatavalid),
      .err_bad_burst   (err_bad_burst),
      .split_count     (split_count)
   );

   // Free-running 10-time-unit clock
   always #5 afu_clk = ~afu_clk;

   // Single comparison point: counts the check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives the upstream request signals
   task automatic applyStimulus(input logic rd, input logic [AW-1:0] addr, input logic [BW-1:0] bc);
      s_read       = rd;
      s_address    = addr;
      s_burstcount = bc;
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge afu_clk);
      #1;
   endtask

   // Handshake monitor for the randomized run; sampled mid-cycle where all signals are stable
   always @(negedge afu_clk) begin
      if (monEn && afu_reset_n) begin
         if (m_read && !m_waitrequest) begin
            int lowPlusLen;
            issuedLines += longint'(m_burstcount);
            lowPlusLen = int'(m_address[5:0]) + int'(m_burstcount);
            checkOutput("subburst_in_page", 64'(lowPlusLen <= 64), 64'd1);
            checkOutput("subburst_nonzero", 64'(m_burstcount != 0), 64'd1);
            checkOutput("pending_request", 64'(qAddr.size() != 0), 64'd1);
            if (qAddr.size() != 0) begin
               checkOutput("subburst_addr", 64'(m_address), 64'(qAddr[0]));
               checkOutput("subburst_len_le_remain", 64'(int'(m_burstcount) <= qRem[0]), 64'd1);
               qAddr[0] = qAddr[0] + AW'(m_burstcount);
               qRem[0]  = qRem[0] - int'(m_burstcount);
               if (qRem[0] <= 0) begin
                  void'(qAddr.pop_front());
                  void'(qRem.pop_front());
               end
            end
         end
         if (s_read && !s_waitrequest) begin
            qAddr.push_back(s_address);
            qRem.push_back(int'(s_burstcount));
            acceptedLines += longint'(s_burstcount);
         end
      end
   end

   // Directed sequence followed by the randomized burst run
   initial begin
      logic [63:0]   rnd;
      logic [AW-1:0] addr;
      logic [BW-1:0] bc;
      logic [DW-1:0] expData;
      logic          expValid;
      bit            accepted;

      afu_reset_n     = 1'b0;
      m_waitrequest   = 1'b0;
      m_readdata      = '0;
      m_readdatavalid = 1'b0;
      applyStimulus(1'b0, '0, '0);
      #2;
      checkOutput("reset_s_waitrequest", 64'(s_waitrequest), 64'd1);
      checkOutput("reset_m_read", 64'(m_read), 64'd0);
      checkOutput("reset_m_address", 64'(m_address), 64'd0);
      checkOutput("reset_m_burstcount", 64'(m_burstcount), 64'd0);
      checkOutput("reset_err", 64'(err_bad_burst), 64'd0);
      checkOutput("reset_split_count", 64'(split_count), 64'd0);
      @(negedge afu_clk);
      afu_reset_n = 1'b1;
      tick();
      checkOutput("idle_s_waitrequest", 64'(s_waitrequest), 64'd0);

      expData         = {16{32'hA5C3_1E07}};
      m_readdata      = expData;
      m_readdatavalid = 1'b1;
      #1;
      checkOutput("passthru_data", 64'(s_readdata === expData), 64'd1);
      checkOutput("passthru_valid", 64'(s_readdatavalid), 64'd1);
      m_readdatavalid = 1'b0;

      // Unsplit burst
      applyStimulus(1'b1, 42'h100, 6'd8);
      tick();
      applyStimulus(1'b0, '0, '0);
      checkOutput("t1_m_read", 64'(m_read), 64'd1);
      checkOutput("t1_m_address", 64'(m_address), 64'h100);
      checkOutput("t1_m_burstcount", 64'(m_burstcount), 64'd8);
      checkOutput("t1_split_count", 64'(split_count), 64'd0);
      tick();
      checkOutput("t1_m_read_drop", 64'(m_read), 64'd0);

      // Page-crossing burst split into 4 + 4
      applyStimulus(1'b1, 42'h13C, 6'd8);
      tick();
      applyStimulus(1'b0, '0, '0);
      checkOutput("t2_sub0_addr", 64'(m_address), 64'h13C);
      checkOutput("t2_sub0_len", 64'(m_burstcount), 64'd4);
      checkOutput("t2_s_waitrequest_split", 64'(s_waitrequest), 64'd1);
      checkOutput("t2_split_count", 64'(split_count), 64'd1);
      tick();
      checkOutput("t2_sub1_read", 64'(m_read), 64'd1);
      checkOutput("t2_sub1_addr", 64'(m_address), 64'h140);
      checkOutput("t2_sub1_len", 64'(m_burstcount), 64'd4);
      checkOutput("t2_s_waitrequest_done", 64'(s_waitrequest), 64'd0);
      tick();
      checkOutput("t2_m_read_drop", 64'(m_read), 64'd0);

      // Same split with the first sub-burst stalled for three cycles
      m_waitrequest = 1'b1;
      applyStimulus(1'b1, 42'h13C, 6'd8);
      tick();
      applyStimulus(1'b0, '0, '0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("t3_hold_read", 64'(m_read), 64'd1);
         checkOutput("t3_hold_addr", 64'(m_address), 64'h13C);
         checkOutput("t3_hold_len", 64'(m_burstcount), 64'd4);
         checkOutput("t3_hold_s_waitrequest", 64'(s_waitrequest), 64'd1);
         if (i < 2) tick();
      end
      m_waitrequest = 1'b0;
      tick();
      checkOutput("t3_sub1_read", 64'(m_read), 64'd1);
      checkOutput("t3_sub1_addr", 64'(m_address), 64'h140);
      checkOutput("t3_sub1_len", 64'(m_burstcount), 64'd4);
      tick();
      checkOutput("t3_m_read_drop", 64'(m_read), 64'd0);
      checkOutput("t3_split_count", 64'(split_count), 64'd2);

      // Illegal zero-length burst followed by a legal single-line burst
      applyStimulus(1'b1, 42'h180, 6'd0);
      tick();
      applyStimulus(1'b1, 42'h200, 6'd1);
      checkOutput("t4_bad_dropped", 64'(m_read), 64'd0);
      checkOutput("t4_err_set", 64'(err_bad_burst), 64'd1);
      tick();
      applyStimulus(1'b0, '0, '0);
      checkOutput("t4_good_read", 64'(m_read), 64'd1);
      checkOutput("t4_good_addr", 64'(m_address), 64'h200);
      checkOutput("t4_good_len", 64'(m_burstcount), 64'd1);
      checkOutput("t4_split_count", 64'(split_count), 64'd2);
      tick();
      checkOutput("t4_err_sticky", 64'(err_bad_burst), 64'd1);

      // Reset in the middle of a split
      applyStimulus(1'b1, 42'h13C, 6'd8);
      tick();
      applyStimulus(1'b0, '0, '0);
      checkOutput("t5_sub0_read", 64'(m_read), 64'd1);
      checkOutput("t5_split_pre_reset", 64'(split_count), 64'd3);
      afu_reset_n = 1'b0;
      #1;
      checkOutput("t5_reset_m_read", 64'(m_read), 64'd0);
      checkOutput("t5_reset_split_count", 64'(split_count), 64'd0);
      checkOutput("t5_reset_err", 64'(err_bad_burst), 64'd0);
      checkOutput("t5_reset_s_waitrequest", 64'(s_waitrequest), 64'd1);
      @(negedge afu_clk);
      afu_reset_n = 1'b1;
      tick();
      checkOutput("t5_no_leftover", 64'(m_read), 64'd0);
      applyStimulus(1'b1, 42'h0, 6'd32);
      tick();
      applyStimulus(1'b0, '0, '0);
      checkOutput("t5_full_read", 64'(m_read), 64'd1);
      checkOutput("t5_full_addr", 64'(m_address), 64'h0);
      checkOutput("t5_full_len", 64'(m_burstcount), 64'd32);
      checkOutput("t5_full_split_count", 64'(split_count), 64'd0);
      tick();
      checkOutput("t5_full_done", 64'(m_read), 64'd0);
      checkOutput("t5_full_s_waitrequest", 64'(s_waitrequest), 64'd0);

      // Randomized bursts with random downstream backpressure
      monEn = 1'b1;
      for (int r = 0; r < 16; r++) begin
         rnd  = {$urandom, $urandom};
         addr = rnd[AW-1:0];
         if (r < 4) addr[5:0] = 6'd60 + 6'(r);
         if (r == 4) addr = '1;
         bc = 6'($urandom_range(1, 32));
         applyStimulus(1'b1, addr, bc);
         accepted = 1'b0;
         for (int c = 0; c < 100 && !accepted; c++) begin
            m_waitrequest   = ($urandom_range(0, 2) == 0);
            rnd             = {$urandom, $urandom};
            expData         = {8{rnd}};
            expValid        = rnd[0];
            m_readdata      = expData;
            m_readdatavalid = expValid;
            #1;
            checkOutput("rand_passthru_data", 64'(s_readdata === expData), 64'd1);
            checkOutput("rand_passthru_valid", 64'(s_readdatavalid), 64'(expValid));
            accepted = !s_waitrequest;
            tick();
         end
         checkOutput("rand_accept_in_budget", 64'(accepted), 64'd1);
      end
      applyStimulus(1'b0, '0, '0);
      for (int c = 0; c < 200 && (m_read || qAddr.size() != 0); c++) begin
         m_waitrequest = ($urandom_range(0, 2) == 0);
         tick();
      end
      m_waitrequest = 1'b0;
      tick();
      monEn = 1'b0;
      checkOutput("rand_drained", 64'(m_read), 64'd0);
      checkOutput("rand_queue_empty", 64'(qAddr.size()), 64'd0);
      checkOutput("rand_line_totals", 64'(issuedLines), 64'(acceptedLines));
      checkOutput("rand_err_clear", 64'(err_bad_burst), 64'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
